issue_scheduler: RTL and testbench
==================================

Name: issue_scheduler

Overview:
- Sits between the wakeup stage and the execution units.
- Takes the two oldest executable candidates each cycle and grants them to free execution lanes: 2 ALU lanes, 1 memory lane, 1 iterative multiply lane.
- Holds issued ops in registered lane slots, enforces memory back-pressure and multiply occupancy, and squashes issued ops on a branch-mispredict flush.
- Grants return to the reservation buffer so it can advance the entry's e_state.

Parameters:
MUL_LAT, 4, cycles the multiply unit stays occupied per op (legal range 1..15).
STALL_W, 32, width of the stall statistics counter.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-high reset.
cand[2]  input  2 x $bits(ex_content_t)  wakeup candidates; cand[0] is older and has priority; is_valid qualifies each.
grant[2]  output  1 each  combinational; candidate k is accepted into a lane at this clock edge.
alu_out[2]  output  $bits(ex_content_t) each  registered ALU lane slots; is_valid marks an issued op.
mem_out  output  $bits(ex_content_t)  registered memory lane slot (Unit LOAD/STORE).
mem_ready  input  1  memory unit consumes mem_out when mem_out.is_valid && mem_ready.
mul_out  output  $bits(ex_content_t)  registered multiply lane slot; valid for exactly one cycle per op.
flush  input  1  mispredict flush strobe.
flush_mask  input  $bits(spectag_t)  speculative tags being killed.
stall_count  output  STALL_W  saturating count of lost-candidate cycles.

Behaviour:
- Lane class from cand.Unit:
  - LOAD/STORE → MEM.
  - Multiply unit → MUL.
  - Everything else → ALU, including ops whose mode is EX_GEN_ADDR (these always carry Unit = ALU).
- Reset:
  - All lane slots are cleared (is_valid = 0, payload 0).
  - mul_busy counter = 0; stall_count = 0; grant = 0.
  - Reset asserted mid-operation drops all in-flight slots with no handshake.
- ALU lanes:
  - Single-cycle; both slots are reloaded every cycle.
  - Two ALU candidates: cand[0] → alu_out[0], cand[1] → alu_out[1].
  - One ALU candidate: it goes to alu_out[0]; alu_out[1].is_valid = 0.
  - Latency: grant in cycle t → alu_out valid in cycle t+1 for one cycle only.
- MEM lane:
  - mem_free = !mem_out.is_valid || mem_ready.
  - At most one MEM grant per cycle, to the older eligible candidate.
  - If mem_free is 0, the slot holds its value and payload stable.
  - Consume and reload in the same cycle is legal and leaves no bubble.
- MUL lane:
  - mul_free = (mul_busy == 0).
  - Grant: mul_out valid in cycle t+1, and mul_busy is loaded with MUL_LAT-1 at that edge.
  - mul_busy decrements each cycle while nonzero, so the next MUL grant is possible at cycle t+MUL_LAT earliest.
  - At most one MUL grant per cycle.
- Grant rule:
  - grant[k] = cand[k].is_valid && lane for cand[k] is available after any older grant in the same cycle && !flush.
  - If cand[0] is not granted, cand[1] may still be granted when its own lane is free (no in-order constraint).
- Flush:
  - While flush = 1, both grants are 0.
  - At the edge, every valid slot (alu, mem, mul) with (speculative_tag & flush_mask) != 0 is invalidated.
  - Surviving slots behave normally, including a mem_ready consume.
  - mul_busy keeps counting; the unit is physically occupied.
  - flush_mask = 0 kills nothing.
- stall_count increments by 1 per cycle in which any valid candidate is not granted and flush = 0. It saturates at all-ones.

Test Plan:
- Two ALU cands, tags 5 and 6 → grant = 2'b11; next cycle alu_out[0].tag = 5, alu_out[1].tag = 6; both slots invalid the cycle after if there is no new input.
- Two LOAD cands, mem_ready = 1 → only grant[0]; repeat next cycle with mem_ready = 0 → grant = 0, mem_out holds the first tag stable, stall_count = 2; raise mem_ready → slot refills with no bubble.
- MUL_LAT = 4: MUL cand offered continuously → grants at cycles 0, 4, 8; mul_out valid only at cycles 1, 5, 9; stall_count = 6 after cycle 8.
- cand[0] = MUL while busy, cand[1] = ALU tag 9 → grant = 2'b10; alu_out[0].tag = 9 next cycle.
- mem_out valid with speculative_tag 4'b0010 and alu_out[0] valid with tag 4'b0001; flush with flush_mask = 4'b0010 → mem_out invalid next edge, alu_out[0] unaffected by the kill, grant = 0 during flush; flush_mask = 0 → nothing killed.
- Assert reset asynchronously mid-cycle while mem_out is held and mul_busy = 2 → all slots invalid immediately, stall_count = 0, and a MUL grant is possible in the first cycle after reset release.

Source files
------------

// File: rtl/issue_scheduler.sv
// ----------------------------------------------------------------------------
// issue_scheduler
//
// Purpose:
//   Takes the two oldest wakeup candidates each cycle and grants them to free
//   execution lanes (2 ALU, 1 memory, 1 iterative multiply). Issued ops are
//   held in registered lane slots. The memory slot honours back-pressure from
//   the memory unit. The multiply lane is blocked while the unit is occupied.
//   A branch-mispredict flush squashes issued ops whose speculative tag is
//   being killed.
//
// Ports:
//   clk          system clock, rising-edge active
//   reset        asynchronous active-high reset
//   cand[2]      wakeup candidates, cand[0] older and higher priority
//   grant[1:0]   combinational accept strobe per candidate
//   alu_out[2]   registered ALU lane slots (single-cycle)
//   mem_out      registered memory lane slot (LOAD/STORE)
//   mem_ready    memory unit consumes mem_out when valid && ready
//   mul_out      registered multiply lane slot, valid one cycle per op
//   flush        mispredict flush strobe
//   flush_mask   speculative tags being killed
//   stall_count  saturating count of cycles that lost a candidate
// ----------------------------------------------------------------------------

package issue_scheduler_pkg;

   typedef logic [3:0] spectag_t;

   typedef enum logic [2:0] {
      UNIT_ALU    = 3'd0,
      UNIT_LOAD   = 3'd1,
      UNIT_STORE  = 3'd2,
      UNIT_MUL    = 3'd3,
      UNIT_BRANCH = 3'd4
   } unit_t;

   typedef enum logic [1:0] {
      EX_NORMAL   = 2'd0,
      EX_GEN_ADDR = 2'd1,
      EX_BRANCH   = 2'd2
   } ex_mode_t;

   typedef struct packed {
      logic       is_valid;
      unit_t      Unit;
      ex_mode_t   mode;
      logic [5:0] tag;
      spectag_t   speculative_tag;
      logic [31:0] data;
   } ex_content_t;

   typedef enum logic [1:0] {
      LANE_ALU = 2'd0,
      LANE_MEM = 2'd1,
      LANE_MUL = 2'd2
   } lane_t;

endpackage

module issue_scheduler
   import issue_scheduler_pkg::*;
#(
   parameter int MUL_LAT = 4,
   parameter int STALL_W = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  ex_content_t        cand [2],
   output logic [1:0]         grant,
   output ex_content_t        alu_out [2],
   output ex_content_t        mem_out,
   input  logic               mem_ready,
   output ex_content_t        mul_out,
   input  logic               flush,
   input  spectag_t           flush_mask,
   output logic [STALL_W-1:0] stall_count
);

   // Address-generation ops carry Unit = ALU, so they fall into the ALU class.
   function automatic lane_t laneOf(input ex_content_t c);
      case (c.Unit)
         UNIT_LOAD, UNIT_STORE: laneOf = LANE_MEM;
         UNIT_MUL:              laneOf = LANE_MUL;
         default:               laneOf = LANE_ALU;
      endcase
   endfunction

   logic [3:0]  r_mulBusy;
   lane_t       w_lane0;
   lane_t       w_lane1;
   logic        w_memFree;
   logic        w_mulFree;
   logic        w_grant0;
   logic        w_grant1;
   logic        w_memTaken;
   logic        w_mulTaken;
   logic        w_anyStall;
   logic        w_memKill;
   logic        w_memLoad;
   logic        w_mulLoad;
   ex_content_t w_memSel;
   ex_content_t w_mulSel;
   ex_content_t w_alu0Next;
   ex_content_t w_alu1Next;

   assign w_lane0   = laneOf(cand[0]);
   assign w_lane1   = laneOf(cand[1]);
   assign w_memFree = !mem_out.is_valid || mem_ready;
   assign w_mulFree = (r_mulBusy == 4'd0);
   assign grant     = {w_grant1, w_grant0};

   // Grant arbitration. cand[0] claims its lane first; cand[1] may still
   // issue into its own lane even when cand[0] is blocked. The two ALU lanes
   // can never both be taken by a single older grant, so ALU is always free.
   always_comb begin
      w_grant0   = 1'b0;
      w_grant1   = 1'b0;
      w_memTaken = 1'b0;
      w_mulTaken = 1'b0;
      if (cand[0].is_valid && !flush && !reset) begin
         case (w_lane0)
            LANE_MEM: w_grant0 = w_memFree;
            LANE_MUL: w_grant0 = w_mulFree;
            default:  w_grant0 = 1'b1;
         endcase
      end
      w_memTaken = w_grant0 && (w_lane0 == LANE_MEM);
      w_mulTaken = w_grant0 && (w_lane0 == LANE_MUL);
      if (cand[1].is_valid && !flush && !reset) begin
         case (w_lane1)
            LANE_MEM: w_grant1 = w_memFree && !w_memTaken;
            LANE_MUL: w_grant1 = w_mulFree && !w_mulTaken;
            default:  w_grant1 = 1'b1;
         endcase
      end
   end

   // Lane slot next-values. A lone ALU grant always lands in slot 0.
   always_comb begin
      w_alu0Next = '0;
      w_alu1Next = '0;
      w_memLoad  = 1'b0;
      w_memSel   = '0;
      w_mulLoad  = 1'b0;
      w_mulSel   = '0;
      if (w_grant0 && (w_lane0 == LANE_ALU)) begin
         w_alu0Next = cand[0];
         if (w_grant1 && (w_lane1 == LANE_ALU)) begin
            w_alu1Next = cand[1];
         end
      end else if (w_grant1 && (w_lane1 == LANE_ALU)) begin
         w_alu0Next = cand[1];
      end
      if (w_grant0 && (w_lane0 == LANE_MEM)) begin
         w_memLoad = 1'b1;
         w_memSel  = cand[0];
      end else if (w_grant1 && (w_lane1 == LANE_MEM)) begin
         w_memLoad = 1'b1;
         w_memSel  = cand[1];
      end
      if (w_grant0 && (w_lane0 == LANE_MUL)) begin
         w_mulLoad = 1'b1;
         w_mulSel  = cand[0];
      end else if (w_grant1 && (w_lane1 == LANE_MUL)) begin
         w_mulLoad = 1'b1;
         w_mulSel  = cand[1];
      end
   end

   // Grants are suppressed during flush, so only the held memory slot can
   // actually carry a killable op across the flush edge.
   assign w_memKill  = flush && mem_out.is_valid &&
                       ((mem_out.speculative_tag & flush_mask) != '0);
   assign w_anyStall = !flush &&
                       ((cand[0].is_valid && !w_grant0) ||
                        (cand[1].is_valid && !w_grant1));

   // ALU and multiply slots are reloaded every cycle, which also empties any
   // slot whose op would otherwise be killed by a flush.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         alu_out[0] <= '0;
         alu_out[1] <= '0;
         mul_out    <= '0;
      end else begin
         alu_out[0] <= w_alu0Next;
         alu_out[1] <= w_alu1Next;
         mul_out    <= w_mulLoad ? w_mulSel : '0;
      end
   end

   // Memory slot: reload wins (covers consume-and-reload with no bubble),
   // otherwise a consume or a flush kill empties it, otherwise it holds.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem_out <= '0;
      end else if (w_memLoad) begin
         mem_out <= w_memSel;
      end else if (mem_out.is_valid && (mem_ready || w_memKill)) begin
         mem_out <= '0;
      end
   end

   // Multiply occupancy keeps counting through a flush because the unit is
   // still physically busy with the squashed op.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_mulBusy <= 4'd0;
      end else if (w_mulLoad) begin
         r_mulBusy <= 4'(MUL_LAT - 1);
      end else if (r_mulBusy != 4'd0) begin
         r_mulBusy <= r_mulBusy - 4'd1;
      end
   end

   // Saturating lost-candidate counter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_count <= '0;
      end else if (w_anyStall && (stall_count != {STALL_W{1'b1}})) begin
         stall_count <= stall_count + STALL_W'(1);
      end
   end

endmodule

// File: tb/tb_issue_scheduler.sv
// ----------------------------------------------------------------------------
// tb_issue_scheduler
//
// Purpose:
//   Self-checking bench for issue_scheduler. A table of directed vectors
//   (inputs plus hand-computed grants and post-edge slot contents) is applied
//   cycle by cycle, followed by hand-written sequences for asynchronous reset
//   and for stall-counter saturation on a second, narrow instance.
// ----------------------------------------------------------------------------

module tb_issue_scheduler;
   import issue_scheduler_pkg::*;

   typedef struct {
      string       name;
      ex_content_t c0;
      ex_content_t c1;
      logic        memReady;
      logic        flush;
      spectag_t    mask;
      logic [1:0]  expGrant;
      logic [6:0]  expAlu0;
      logic [6:0]  expAlu1;
      logic [6:0]  expMem;
      logic [6:0]  expMul;
      int          expStall;
   } vec_t;

   localparam logic [6:0] NO = 7'h00;

   logic        clk;
   logic        reset;
   ex_content_t cand [2];
   logic [1:0]  grant;
   ex_content_t alu_out [2];
   ex_content_t mem_out;
   logic        mem_ready;
   ex_content_t mul_out;
   logic        flush;
   spectag_t    flush_mask;
   logic [31:0] stall_count;

   ex_content_t sCand [2];
   logic [1:0]  sGrant;
   ex_content_t sAluOut [2];
   ex_content_t sMemOut;
   ex_content_t sMulOut;
   logic [1:0]  sStall;

   int   total;
   int   bad;
   vec_t vecs[$];

   issue_scheduler #(.MUL_LAT(4), .STALL_W(32)) dut (
      .clk         (clk),
      .reset       (reset),
      .cand        (cand),
      .grant       (grant),
      .alu_out     (alu_out),
      .mem_out     (mem_out),
      .mem_ready   (mem_ready),
      .mul_out     (mul_out),
      .flush       (flush),
      .flush_mask  (flush_mask),
      .stall_count (stall_count)
   );

   issue_scheduler #(.MUL_LAT(1), .STALL_W(2)) dutSat (
      .clk         (clk),
      .reset       (reset),
      .cand        (sCand),
      .grant       (sGrant),
      .alu_out     (sAluOut),
      .mem_out     (sMemOut),
      .mem_ready   (1'b1),
      .mul_out     (sMulOut),
      .flush       (1'b0),
      .flush_mask  (4'b0000),
      .stall_count (sStall)
   );

   // Free-running clock, period 10.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic ex_content_t op(input unit_t u, input int t, input spectag_t s);
      ex_content_t c;
      c                 = '0;
      c.is_valid        = 1'b1;
      c.Unit            = u;
      c.tag             = 6'(t);
      c.speculative_tag = s;
      c.data            = 32'(t) * 32'd3;
      return c;
   endfunction

   function automatic logic [6:0] vt(input int t);
      return {1'b1, 6'(t)};
   endfunction

   function automatic logic [6:0] slotOf(input ex_content_t s);
      return s.is_valid ? {1'b1, s.tag} : 7'h00;
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic addVec(input string n, input ex_content_t c0, input ex_content_t c1,
                         input logic rdy, input logic fl, input spectag_t m,
                         input logic [1:0] g, input logic [6:0] a0, input logic [6:0] a1,
                         input logic [6:0] me, input logic [6:0] mu, input int st);
      vec_t v;
      v.name = n; v.c0 = c0; v.c1 = c1; v.memReady = rdy; v.flush = fl; v.mask = m;
      v.expGrant = g; v.expAlu0 = a0; v.expAlu1 = a1; v.expMem = me; v.expMul = mu;
      v.expStall = st;
      vecs.push_back(v);
   endtask

   // Drive one vector at the falling edge, check grant mid-cycle, then check
   // the registered slots just after the rising edge.
   task automatic applyStimulus(input vec_t v);
      @(negedge clk);
      cand[0]    = v.c0;
      cand[1]    = v.c1;
      mem_ready  = v.memReady;
      flush      = v.flush;
      flush_mask = v.mask;
      #1;
      checkOutput({v.name, ".grant"}, 64'(grant), 64'(v.expGrant));
      @(posedge clk);
      #1;
      checkOutput({v.name, ".alu0"}, 64'(slotOf(alu_out[0])), 64'(v.expAlu0));
      checkOutput({v.name, ".alu1"}, 64'(slotOf(alu_out[1])), 64'(v.expAlu1));
      checkOutput({v.name, ".mem"}, 64'(slotOf(mem_out)), 64'(v.expMem));
      checkOutput({v.name, ".mul"}, 64'(slotOf(mul_out)), 64'(v.expMul));
      checkOutput({v.name, ".stall"}, 64'(stall_count), 64'(v.expStall));
   endtask

   initial begin
      ex_content_t none;
      none       = '0;
      total      = 0;
      bad        = 0;
      cand[0]    = none;
      cand[1]    = none;
      sCand[0]   = none;
      sCand[1]   = none;
      mem_ready  = 1'b0;
      flush      = 1'b0;
      flush_mask = 4'b0000;
      reset      = 1'b1;

      //      name    c0                           c1                          rdy fl mask     grant  alu0    alu1    mem      mul      stall
      addVec("alu2",  op(UNIT_ALU, 5, 0),          op(UNIT_ALU, 6, 0),         1,  0, 4'b0000, 2'b11, vt(5),  vt(6),  NO,      NO,      0);
      addVec("idle",  none,                        none,                       1,  0, 4'b0000, 2'b00, NO,     NO,     NO,      NO,      0);
      addVec("ld2",   op(UNIT_LOAD, 10, 0),        op(UNIT_LOAD, 11, 0),       1,  0, 4'b0000, 2'b01, NO,     NO,     vt(10),  NO,      1);
      addVec("ldBp",  op(UNIT_LOAD, 10, 0),        op(UNIT_LOAD, 11, 0),       0,  0, 4'b0000, 2'b00, NO,     NO,     vt(10),  NO,      2);
      addVec("ldRe",  op(UNIT_STORE, 12, 0),       op(UNIT_LOAD, 13, 0),       1,  0, 4'b0000, 2'b01, NO,     NO,     vt(12),  NO,      3);
      addVec("drain", none,                        none,                       1,  0, 4'b0000, 2'b00, NO,     NO,     NO,      NO,      3);
      addVec("mul0",  op(UNIT_MUL, 20, 0),         none,                       1,  0, 4'b0000, 2'b01, NO,     NO,     NO,      vt(20),  3);
      addVec("mul1",  op(UNIT_MUL, 20, 0),         none,                       1,  0, 4'b0000, 2'b00, NO,     NO,     NO,      NO,      4);
      addVec("mul2",  op(UNIT_MUL, 20, 0),         none,                       1,  0, 4'b0000, 2'b00, NO,     NO,     NO,      NO,      5);
      addVec("mul3",  op(UNIT_MUL, 20, 0),         none,                       1,  0, 4'b0000, 2'b00, NO,     NO,     NO,      NO,      6);
      addVec("mul4",  op(UNIT_MUL, 20, 0),         none,                       1,  0, 4'b0000, 2'b01, NO,     NO,     NO,      vt(20),  6);
      addVec("mul5",  op(UNIT_MUL, 20, 0),         none,                       1,  0, 4'b0000, 2'b00, NO,     NO,     NO,      NO,      7);
      addVec("mul6",  op(UNIT_MUL, 20, 0),         none,                       1,  0, 4'b0000, 2'b00, NO,     NO,     NO,      NO,      8);
      addVec("mul7",  op(UNIT_MUL, 20, 0),         none,                       1,  0, 4'b0000, 2'b00, NO,     NO,     NO,      NO,      9);
      addVec("mul8",  op(UNIT_MUL, 20, 0),         none,                       1,  0, 4'b0000, 2'b01, NO,     NO,     NO,      vt(20),  9);
      addVec("bypass",op(UNIT_MUL, 21, 0),         op(UNIT_ALU, 9, 0),         1,  0, 4'b0000, 2'b10, vt(9),  NO,     NO,      NO,      10);
      addVec("mix",   op(UNIT_ALU, 1, 4'b0001),    op(UNIT_STORE, 2, 4'b0010), 0,  0, 4'b0000, 2'b11, vt(1),  NO,     vt(2),   NO,      10);
      addVec("flsh0", op(UNIT_ALU, 3, 0),          none,                       0,  1, 4'b0000, 2'b00, NO,     NO,     vt(2),   NO,      10);
      addVec("alu1",  op(UNIT_ALU, 4, 4'b0001),    none,                       0,  0, 4'b0000, 2'b01, vt(4),  NO,     vt(2),   NO,      10);
      addVec("flshK", op(UNIT_MUL, 23, 0),         none,                       0,  1, 4'b0010, 2'b00, NO,     NO,     NO,      NO,      10);
      addVec("mulOk", op(UNIT_MUL, 22, 0),         none,                       0,  0, 4'b0000, 2'b01, NO,     NO,     NO,      vt(22),  10);
      addVec("ldHld", op(UNIT_LOAD, 30, 0),        none,                       0,  0, 4'b0000, 2'b01, NO,     NO,     vt(30),  NO,      10);

      // Reset state, with a candidate offered to show grant is held low.
      cand[0] = op(UNIT_ALU, 7, 0);
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst.grant", 64'(grant), 64'(2'b00));
      checkOutput("rst.alu0", 64'(slotOf(alu_out[0])), 64'(NO));
      checkOutput("rst.mem", 64'(slotOf(mem_out)), 64'(NO));
      checkOutput("rst.stall", 64'(stall_count), 64'd0);
      @(negedge clk);
      cand[0] = none;
      reset   = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i]);
      end

      // Mid-cycle asynchronous reset while mem_out is held and the multiplier
      // still has two busy cycles left.
      cand[0]   = op(UNIT_MUL, 40, 0);
      cand[1]   = none;
      mem_ready = 1'b0;
      #2;
      checkOutput("pre.grant", 64'(grant), 64'(2'b00));
      reset = 1'b1;
      #1;
      checkOutput("arst.mem", 64'(slotOf(mem_out)), 64'(NO));
      checkOutput("arst.alu0", 64'(slotOf(alu_out[0])), 64'(NO));
      checkOutput("arst.mul", 64'(slotOf(mul_out)), 64'(NO));
      checkOutput("arst.stall", 64'(stall_count), 64'd0);
      checkOutput("arst.grant", 64'(grant), 64'(2'b00));
      @(negedge clk);
      reset = 1'b0;
      #1;
      checkOutput("post.grant", 64'(grant), 64'(2'b01));
      @(posedge clk);
      #1;
      checkOutput("post.mul", 64'(slotOf(mul_out)), 64'(vt(40)));
      @(negedge clk);
      cand[0] = none;

      // Narrow instance: MUL_LAT = 1 grants a multiply every cycle, and the
      // always-losing second multiply drives the 2-bit counter to saturation.
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         sCand[0] = op(UNIT_MUL, i, 0);
         sCand[1] = op(UNIT_MUL, i + 8, 0);
         #1;
         checkOutput("sat.grant", 64'(sGrant), 64'(2'b01));
         @(posedge clk);
         #1;
         checkOutput("sat.mul", 64'(slotOf(sMulOut)), 64'(vt(i)));
         checkOutput("sat.stall", 64'(sStall), 64'((i + 1 > 3) ? 3 : i + 1));
      end
      @(negedge clk);
      sCand[0] = none;
      sCand[1] = none;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
